// File: rtl/fir_filter_param_if.sv
// Streaming sample / coefficient-load bundle for fir_filter_param.
// The master side is the sample source plus coefficient loader.
// The slave side is the filter itself.
interface fir_filter_param_if #(
  parameter int NTAPS  = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int AW     = $clog2(NTAPS)
) ();

  logic signed [DATA_W-1:0] x_in;
  logic                     x_valid;
  logic                     clr;
  logic                     coef_wr;
  logic        [AW-1:0]     coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic signed [OUT_W-1:0]  y_out;
  logic                     y_valid;
  logic                     y_sat;

  modport master (
    output x_in, x_valid, clr, coef_wr, coef_addr, coef_data,
    input  y_out, y_valid, y_sat
  );

  modport slave (
    input  x_in, x_valid, clr, coef_wr, coef_addr, coef_data,
    output y_out, y_valid, y_sat
  );

endinterface

// File: rtl/fir_filter_param.sv
// Parametrised pipelined direct-form FIR filter.
// The filter has three register stages:
//   1. delay line
//   2. per-tap products
//   3. rounded and saturated output
// Coefficients are loaded at runtime and survive a pipeline clear.
// Only reset wipes the coefficients.
module fir_filter_param #(
  parameter int NTAPS  = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  fir_filter_param_if.slave  bus
);

  localparam int AW     = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);
  localparam int RSH    = (SHIFT > 0) ? SHIFT - 1 : 0;

  // The rounding and scaling path is one bit wider than the accumulator.
  // This keeps the half-LSB addition from ever wrapping.
  localparam logic signed [ACC_W:0] ROUND =
    (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RSH) : '0;

  localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   Y_MAX_W = {{(ACC_W+1-OUT_W){1'b0}}, Y_MAX};
  localparam logic signed [ACC_W:0]   Y_MIN_W = {{(ACC_W+1-OUT_W){1'b1}}, Y_MIN};
  localparam logic        [AW:0]      TAP_COUNT = (AW+1)'(NTAPS);

  logic signed [COEF_W-1:0] coef [NTAPS];
  logic signed [DATA_W-1:0] d    [NTAPS];
  logic signed [PROD_W-1:0] p    [NTAPS];
  logic                     v0;
  logic                     v1;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    scaled;
  logic signed [OUT_W-1:0]  clip_val;
  logic                     clip_flag;

  // Coefficient bank.
  // Writes beyond the last tap are dropped.
  // A clear does not touch the coefficients.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
    end else if (bus.coef_wr && ({1'b0, bus.coef_addr} < TAP_COUNT)) begin
      coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Delay line.
  // The line shifts only on accepted samples, so gaps never inject zeros.
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      for (int k = 0; k < NTAPS; k++) d[k] <= '0;
      v0 <= 1'b0;
    end else begin
      v0 <= bus.x_valid;
      if (bus.x_valid) begin
        d[0] <= bus.x_in;
        for (int k = 1; k < NTAPS; k++) d[k] <= d[k-1];
      end
    end
  end

  // Product stage.
  // Products are captured once per accepted sample, using the current coefficients.
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      for (int k = 0; k < NTAPS; k++) p[k] <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= v0;
      if (v0) begin
        for (int k = 0; k < NTAPS; k++) p[k] <= d[k] * coef[k];
      end
    end
  end

  // Sum the products, round half up, scale, then clip to the output range.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc = acc + $signed({{(ACC_W-PROD_W){p[k][PROD_W-1]}}, p[k]});
    end
    rounded = $signed({acc[ACC_W-1], acc}) + ROUND;
    scaled  = rounded >>> SHIFT;
    if (scaled > Y_MAX_W) begin
      clip_val  = Y_MAX;
      clip_flag = 1'b1;
    end else if (scaled < Y_MIN_W) begin
      clip_val  = Y_MIN;
      clip_flag = 1'b1;
    end else begin
      clip_val  = scaled[OUT_W-1:0];
      clip_flag = 1'b0;
    end
  end

  // Output register.
  // y_out and y_sat hold between results.
  // y_valid pulses once per sample.
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      bus.y_out   <= '0;
      bus.y_sat   <= 1'b0;
      bus.y_valid <= 1'b0;
    end else begin
      bus.y_valid <= v1;
      if (v1) begin
        bus.y_out <= clip_val;
        bus.y_sat <= clip_flag;
      end
    end
  end

endmodule
